// File: rtl/program_mem.sv
// program_mem: loadable MiniAlu instruction memory with a registered fetch port and a valid/ready download port.
// Defining PROGMEM_CHECKSUM_EN adds oChecksum, a 16-bit running sum of the downloaded words.
module program_mem #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iFetchEn,
    input  logic [15:0]           iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    input  logic                  iLoadStart,
    input  logic                  iLoadValid,
    input  logic                  iLoadLast,
    input  logic [DATA_WIDTH-1:0] iLoadData,
    output logic                  oLoadReady,
    output logic                  oLoadDone,
    output logic                  oLoadOvf,
    output logic [1:0]            oState
`ifdef PROGMEM_CHECKSUM_EN
   ,output logic [15:0]           oChecksum
`endif
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic accept, finish, fetch_ok, out_range;
    assign oLoadReady = state == LOAD;
    // A restart pulse wins over a word offered in the same cycle
    assign accept = iLoadValid && oLoadReady && !iLoadStart;
    assign finish = accept && (iLoadLast || &ptr);
    assign fetch_ok = iFetchEn && !iLoadStart && state != LOAD;
    assign out_range = 32'(iAddress) >= DEPTH;
    assign oState = state;
    always_comb state_nxt = iLoadStart ? LOAD : finish ? RUN : state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            oLoadDone <= 1'b0;
            oLoadOvf <= 1'b0;
            oValid <= 1'b0;
            oInstruction <= FILL_WORD;
        end else begin
            state <= state_nxt;
            oLoadDone <= finish;
            oValid <= fetch_ok;
            if (iLoadStart) begin
                ptr <= '0;
                oLoadOvf <= 1'b0;
            end else if (accept) begin
                ptr <= ptr + ADDR_WIDTH'(1);
                oLoadOvf <= oLoadOvf | (&ptr && !iLoadLast);
            end
            if (fetch_ok)
                oInstruction <= (state == IDLE || out_range) ? FILL_WORD : mem[iAddress[ADDR_WIDTH-1:0]];
        end
    end
    // Array has no reset so a partial download survives a reset
    always_ff @(posedge clk)
        if (accept) mem[ptr] <= iLoadData;
`ifdef PROGMEM_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) oChecksum <= '0;
        else if (iLoadStart) oChecksum <= '0;
        else if (accept) oChecksum <= oChecksum + iLoadData[15:0] + 16'(iLoadData[DATA_WIDTH-1:16]);
`endif
endmodule

// File: tb/tb_program_mem.sv
// tb_program_mem: scoreboard bench for program_mem; a second instance with ADDR_WIDTH = 2 covers overflow.
module tb_program_mem;
    typedef struct {logic v; logic [27:0] d;} fexp_t;
    logic clk, rst_n;
    logic fe, ls, lv, ll;
    logic [15:0] addr;
    logic [27:0] ld, instr;
    logic valid, ready, done, ovf;
    logic [1:0] st;
    logic b_fe, b_ls, b_lv, b_ll;
    logic [15:0] b_addr;
    logic [27:0] b_ld, b_instr;
    logic b_valid, b_ready, b_done, b_ovf;
    logic [1:0] b_st;
`ifdef PROGMEM_CHECKSUM_EN
    logic [15:0] csum, b_csum;
`endif
    fexp_t q[$];
    fexp_t e;
    int pass_cnt = 0, total = 0;
    logic [27:0] held;

    program_mem dut (
        .clk(clk), .rst_n(rst_n), .iFetchEn(fe), .iAddress(addr), .oInstruction(instr), .oValid(valid),
        .iLoadStart(ls), .iLoadValid(lv), .iLoadLast(ll), .iLoadData(ld), .oLoadReady(ready),
        .oLoadDone(done), .oLoadOvf(ovf), .oState(st)
`ifdef PROGMEM_CHECKSUM_EN
       ,.oChecksum(csum)
`endif
    );

    program_mem #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .iFetchEn(b_fe), .iAddress(b_addr), .oInstruction(b_instr), .oValid(b_valid),
        .iLoadStart(b_ls), .iLoadValid(b_lv), .iLoadLast(b_ll), .iLoadData(b_ld), .oLoadReady(b_ready),
        .oLoadDone(b_done), .oLoadOvf(b_ovf), .oState(b_st)
`ifdef PROGMEM_CHECKSUM_EN
       ,.oChecksum(b_csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic quiet();
        fe = 0; ls = 0; lv = 0; ll = 0; addr = '0; ld = '0;
        b_fe = 0; b_ls = 0; b_lv = 0; b_ll = 0; b_addr = '0; b_ld = '0;
    endtask

    task automatic start_load();
        ls = 1;
        @(negedge clk);
        ls = 0;
    endtask

    task automatic put(input logic [27:0] w, input logic last);
        lv = 1; ld = w; ll = last;
        @(negedge clk);
        lv = 0; ll = 0;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 0;
        repeat (2) @(negedge clk);
        total += 6;
        if (instr !== 28'h0) $display("FAIL reset_instr got %h want 0", instr); else pass_cnt++;
        if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else pass_cnt++;
        if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else pass_cnt++;
        if (st !== 2'd0) $display("FAIL reset_state got %0d want 0", st); else pass_cnt++;
        rst_n = 1;
        @(negedge clk);
        fe = 1; addr = 16'd5;
        q.push_back('{1'b1, 28'h0});
        @(negedge clk);
        fe = 0;
        e = q.pop_front();
        total += 3;
        if (valid !== e.v) $display("FAIL idle_fetch_valid got %b want %b", valid, e.v); else pass_cnt++;
        if (instr !== e.d) $display("FAIL idle_fetch_instr got %h want %h", instr, e.d); else pass_cnt++;
        if (st !== 2'd0) $display("FAIL idle_fetch_state got %0d want 0", st); else pass_cnt++;
    endtask

    task automatic test_load();
        logic [27:0] w[3] = '{28'h0A00FA0, 28'h1070001, 28'h2030001};
        logic [15:0] fa[4] = '{16'd0, 16'd1, 16'd2, 16'h0100};
        logic [27:0] fd[4] = '{28'h0A00FA0, 28'h1070001, 28'h2030001, 28'h0};
        start_load();
        total += 2;
        if (ready !== 1'b1) $display("FAIL load_ready got %b want 1", ready); else pass_cnt++;
        if (st !== 2'd1) $display("FAIL load_state got %0d want 1", st); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            put(w[i], i == 2);
            total++;
            if (done !== (i == 2)) $display("FAIL load_done_%0d got %b want %b", i, done, i == 2); else pass_cnt++;
        end
        total++;
        if (st !== 2'd2) $display("FAIL load_run_state got %0d want 2", st); else pass_cnt++;
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL load_done_pulse got %b want 0", done); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            fe = 1; addr = fa[i];
            q.push_back('{1'b1, fd[i]});
            @(negedge clk);
            e = q.pop_front();
            total += 2;
            if (valid !== e.v) $display("FAIL run_fetch_valid_%0d got %b want %b", i, valid, e.v); else pass_cnt++;
            if (instr !== e.d) $display("FAIL run_fetch_instr_%0d got %h want %h", i, instr, e.d); else pass_cnt++;
        end
        fe = 0;
        @(negedge clk);
        total += 2;
        if (valid !== 1'b0) $display("FAIL nofetch_valid got %b want 0", valid); else pass_cnt++;
        if (instr !== 28'h0) $display("FAIL nofetch_hold got %h want 0", instr); else pass_cnt++;
        held = 28'h0;
    endtask

    task automatic test_stall_and_gaps();
        logic [27:0] fd[3] = '{28'h3333333, 28'h4444444, 28'h2030001};
        start_load();
        fe = 1; addr = 16'd1;
        q.push_back('{1'b0, held});
        @(negedge clk);
        fe = 0;
        e = q.pop_front();
        total += 2;
        if (valid !== e.v) $display("FAIL load_fetch_valid got %b want %b", valid, e.v); else pass_cnt++;
        if (instr !== e.d) $display("FAIL load_fetch_hold got %h want %h", instr, e.d); else pass_cnt++;
        put(28'h3333333, 0);
        repeat (2) @(negedge clk);
        put(28'h4444444, 1);
        total += 2;
        if (st !== 2'd2) $display("FAIL gap_state got %0d want 2", st); else pass_cnt++;
        if (done !== 1'b1) $display("FAIL gap_done got %b want 1", done); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            fe = 1; addr = 16'(i);
            q.push_back('{1'b1, fd[i]});
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (instr !== e.d || valid !== e.v)
                $display("FAIL gap_fetch_%0d got %b/%h want %b/%h", i, valid, instr, e.v, e.d);
            else pass_cnt++;
        end
        fe = 0;
    endtask

    task automatic test_reset_midload();
        logic [27:0] fd[2] = '{28'h7777777, 28'h6666666};
        start_load();
        put(28'h5555555, 0);
        put(28'h6666666, 0);
        rst_n = 0;
        #1;
        total += 6;
        if (st !== 2'd0) $display("FAIL midrst_state got %0d want 0", st); else pass_cnt++;
        if (instr !== 28'h0) $display("FAIL midrst_instr got %h want 0", instr); else pass_cnt++;
        if (valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", valid); else pass_cnt++;
        if (ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", ready); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else pass_cnt++;
        if (ovf !== 1'b0) $display("FAIL midrst_ovf got %b want 0", ovf); else pass_cnt++;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start_load();
        put(28'h7777777, 1);
        for (int i = 0; i < 2; i++) begin
            fe = 1; addr = 16'(i);
            q.push_back('{1'b1, fd[i]});
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (instr !== e.d || valid !== e.v)
                $display("FAIL reload_fetch_%0d got %b/%h want %b/%h", i, valid, instr, e.v, e.d);
            else pass_cnt++;
        end
        fe = 0;
    endtask

    task automatic test_overflow();
        b_ls = 1;
        @(negedge clk);
        b_ls = 0;
        for (int k = 0; k < 5; k++) begin
            b_lv = 1; b_ld = 28'h0B00000 + 28'(k);
            total++;
            if (b_ready !== (k < 4)) $display("FAIL ovf_ready_%0d got %b want %b", k, b_ready, k < 4); else pass_cnt++;
            @(negedge clk);
            total += 2;
            if (b_done !== (k == 3)) $display("FAIL ovf_done_%0d got %b want %b", k, b_done, k == 3); else pass_cnt++;
            if (b_ovf !== (k >= 3)) $display("FAIL ovf_flag_%0d got %b want %b", k, b_ovf, k >= 3); else pass_cnt++;
        end
        b_lv = 0;
        total++;
        if (b_st !== 2'd2) $display("FAIL ovf_state got %0d want 2", b_st); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            b_fe = 1; b_addr = 16'(i);
            q.push_back('{1'b1, i < 4 ? 28'h0B00000 + 28'(i) : 28'h0});
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (b_instr !== e.d || b_valid !== e.v)
                $display("FAIL ovf_fetch_%0d got %b/%h want %b/%h", i, b_valid, b_instr, e.v, e.d);
            else pass_cnt++;
        end
        b_fe = 0;
        b_ls = 1;
        @(negedge clk);
        b_ls = 0;
        total++;
        if (b_ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", b_ovf); else pass_cnt++;
    endtask

    task automatic test_start_with_fetch();
        logic [27:0] fd[2] = '{28'h0000001, 28'h0010002};
        fe = 1; ls = 1; addr = 16'd0;
        q.push_back('{1'b0, 28'h6666666});
        @(negedge clk);
        fe = 0; ls = 0;
        e = q.pop_front();
        total += 3;
        if (valid !== e.v) $display("FAIL startfetch_valid got %b want %b", valid, e.v); else pass_cnt++;
        if (instr !== e.d) $display("FAIL startfetch_hold got %h want %h", instr, e.d); else pass_cnt++;
        if (st !== 2'd1) $display("FAIL startfetch_state got %0d want 1", st); else pass_cnt++;
`ifdef PROGMEM_CHECKSUM_EN
        total++;
        if (csum !== 16'h0) $display("FAIL csum_clear got %h want 0000", csum); else pass_cnt++;
`endif
        put(fd[0], 0);
        put(fd[1], 1);
`ifdef PROGMEM_CHECKSUM_EN
        total++;
        if (csum !== 16'h0004) $display("FAIL csum got %h want 0004", csum); else pass_cnt++;
`endif
        for (int i = 0; i < 2; i++) begin
            fe = 1; addr = 16'(i);
            q.push_back('{1'b1, fd[i]});
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (instr !== e.d || valid !== e.v)
                $display("FAIL csload_fetch_%0d got %b/%h want %b/%h", i, valid, instr, e.v, e.d);
            else pass_cnt++;
        end
        fe = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall_and_gaps();
        test_reset_midload();
        test_overflow();
        test_start_with_fetch();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
